// File: rtl/alu_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_ex_stage                                                  |
// | Purpose  : RV64 integer execute stage. One registered ALU result per     |
// |            accepted operand bundle (latency 1), with zero flag and       |
// |            conditional-branch decision, under a valid/ready handshake    |
// |            on both sides and a flush that drops the held result.         |
// | Ports    : clk, rst            - clock, synchronous active-high reset     |
// |            in_valid/in_ready   - upstream handshake                      |
// |            ALUctl, op_a, op_b  - operation code and 64-bit operands      |
// |            is_word             - 32-bit compute, sign-extended result    |
// |            is_branch, br_func3 - conditional branch qualifier            |
// |            flush               - discard the held result                 |
// |            out_valid/out_ready - downstream handshake                    |
// |            result, zero, br_taken - registered outputs                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ALUctl,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        is_word,
  input  logic        is_branch,
  input  logic [2:0]  br_func3,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        zero,
  output logic        br_taken
);

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SLL  = 4'b0001;
  localparam logic [3:0] c_OP_SLT  = 4'b0010;
  localparam logic [3:0] c_OP_SLTU = 4'b0011;
  localparam logic [3:0] c_OP_XOR  = 4'b0100;
  localparam logic [3:0] c_OP_SRL  = 4'b0101;
  localparam logic [3:0] c_OP_OR   = 4'b0110;
  localparam logic [3:0] c_OP_AND  = 4'b0111;
  localparam logic [3:0] c_OP_SUB  = 4'b1000;
  localparam logic [3:0] c_OP_SRA  = 4'b1101;

  logic        r_out_valid;
  logic [63:0] r_result;
  logic        r_zero;
  logic        r_br_taken;

  logic [31:0] w_a32;
  logic [31:0] w_b32;
  logic [5:0]  w_sh64;
  logic [4:0]  w_sh32;
  logic [63:0] w_r64;
  logic [31:0] w_r32;
  logic [63:0] w_result;
  logic        w_zero;
  logic        w_br_taken;
  logic        w_in_ready;
  logic        w_xfer;

  assign w_a32  = op_a[31:0];
  assign w_b32  = op_b[31:0];
  assign w_sh64 = op_b[5:0];
  assign w_sh32 = op_b[4:0];

  // Full-width datapath.
  always_comb begin
    w_r64 = op_a + op_b;
    case (ALUctl)
      c_OP_ADD:  w_r64 = op_a + op_b;
      c_OP_SLL:  w_r64 = op_a << w_sh64;
      c_OP_SLT:  w_r64 = {63'd0, $signed(op_a) < $signed(op_b)};
      c_OP_SLTU: w_r64 = {63'd0, op_a < op_b};
      c_OP_XOR:  w_r64 = op_a ^ op_b;
      c_OP_SRL:  w_r64 = op_a >> w_sh64;
      c_OP_OR:   w_r64 = op_a | op_b;
      c_OP_AND:  w_r64 = op_a & op_b;
      c_OP_SUB:  w_r64 = op_a - op_b;
      c_OP_SRA:  w_r64 = 64'($signed(op_a) >>> w_sh64);
      default:   w_r64 = op_a + op_b;
    endcase
  end

  // 32-bit datapath for *W operations; shifts see only bits 31:0, so SRL
  // fills from bit 31 with zeros and SRA replicates op_a[31].
  always_comb begin
    w_r32 = w_a32 + w_b32;
    case (ALUctl)
      c_OP_ADD:  w_r32 = w_a32 + w_b32;
      c_OP_SLL:  w_r32 = w_a32 << w_sh32;
      c_OP_SLT:  w_r32 = {31'd0, $signed(w_a32) < $signed(w_b32)};
      c_OP_SLTU: w_r32 = {31'd0, w_a32 < w_b32};
      c_OP_XOR:  w_r32 = w_a32 ^ w_b32;
      c_OP_SRL:  w_r32 = w_a32 >> w_sh32;
      c_OP_OR:   w_r32 = w_a32 | w_b32;
      c_OP_AND:  w_r32 = w_a32 & w_b32;
      c_OP_SUB:  w_r32 = w_a32 - w_b32;
      c_OP_SRA:  w_r32 = 32'($signed(w_a32) >>> w_sh32);
      default:   w_r32 = w_a32 + w_b32;
    endcase
  end

  assign w_result = is_word ? {{32{w_r32[31]}}, w_r32} : w_r64;
  assign w_zero   = (w_result == 64'd0);

  // Branch decision: the decoder sets ALUctl to SUB for beq/bne and to
  // SLT/SLTU for the ordered compares, so bit 0 carries the comparison.
  always_comb begin
    w_br_taken = 1'b0;
    case (br_func3)
      3'b000:         w_br_taken = w_zero;
      3'b001:         w_br_taken = !w_zero;
      3'b100, 3'b110: w_br_taken = w_result[0];
      3'b101, 3'b111: w_br_taken = !w_result[0];
      default:        w_br_taken = 1'b0;
    endcase
    if (!is_branch) begin
      w_br_taken = 1'b0;
    end
  end

  // rst is folded in so nothing is acknowledged upstream while in reset.
  assign w_in_ready = (!r_out_valid || out_ready) && !flush && !rst;
  assign w_xfer     = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= 64'd0;
      r_zero      <= 1'b0;
      r_br_taken  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_zero      <= w_zero;
      r_br_taken  <= w_br_taken;
    end else if (flush || out_ready) begin
      // Data registers deliberately keep their value; only validity drops.
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign br_taken  = r_br_taken;

endmodule
`default_nettype wire
